// File: rtl/multi_channel_clock_divider_if.sv
// rtl/multi_channel_clock_divider_if.sv - configuration write port for the multi-channel divider
interface multi_channel_clock_divider_if #(
  parameter int CH_W      = 2,
  parameter int DIV_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_channel;
  logic [DIV_WIDTH-1:0] cfg_divisor;
  logic [DIV_WIDTH-1:0] cfg_high;
  logic                 cfg_error;

  modport master (
    output cfg_valid, cfg_channel, cfg_divisor, cfg_high,
    input  cfg_ready, cfg_error
  );

  modport slave (
    input  cfg_valid, cfg_channel, cfg_divisor, cfg_high,
    output cfg_ready, cfg_error
  );
endinterface

// File: rtl/multi_channel_clock_divider.sv
// rtl/multi_channel_clock_divider.sv - CHANNELS independent programmable clock dividers
// Updates are queued per channel and only applied at a period boundary (or at once while disabled).
module multi_channel_clock_divider #(
  parameter int CHANNELS        = 4,
  parameter int DIV_WIDTH       = 16,
  parameter int MAX_DIVISION    = 1000,
  parameter int DEFAULT_DIVISOR = 2,
  parameter int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           enable,
  multi_channel_clock_divider_if.slave  cfg,
  input  logic [CHANNELS-1:0]           step_divisor,
  output logic [CHANNELS-1:0]           clock_out,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           pending
);
  localparam logic [CH_W:0] NUM_CH = (CH_W + 1)'(CHANNELS);
  localparam int            PAD    = 1 << CH_W;

  logic [DIV_WIDTH-1:0] div_q   [CHANNELS];
  logic [DIV_WIDTH-1:0] high_q  [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [DIV_WIDTH-1:0] pdiv_q  [CHANNELS];
  logic [DIV_WIDTH-1:0] phigh_q [CHANNELS];
  logic [DIV_WIDTH:0]   div_inc [CHANNELS];
  logic [DIV_WIDTH-1:0] step_div[CHANNELS];

  logic [CHANNELS-1:0]  pend_q, sync1_q, sync2_q, sync3_q, step_edge;
  logic [PAD-1:0]       pend_ext;
  logic                 wr_fire, wr_bad;
  logic [DIV_WIDTH-1:0] wr_high;

  // Pad so an out-of-range channel index still reads a defined ready value
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pend_q;
  end

  assign cfg.cfg_ready = ~pend_ext[cfg.cfg_channel];
  assign wr_fire       = cfg.cfg_valid & cfg.cfg_ready;
  assign wr_bad        = (cfg.cfg_divisor < DIV_WIDTH'(2)) || ({1'b0, cfg.cfg_channel} >= NUM_CH);
  assign wr_high       = (cfg.cfg_high == '0 || cfg.cfg_high >= cfg.cfg_divisor)
                         ? (cfg.cfg_divisor >> 1) : cfg.cfg_high;
  assign step_edge     = sync2_q & ~sync3_q;
  assign pending       = pend_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      div_inc[i]  = {1'b0, div_q[i]} + (DIV_WIDTH + 1)'(1);
      step_div[i] = (div_inc[i] > (DIV_WIDTH + 1)'(MAX_DIVISION))
                    ? DIV_WIDTH'(2) : div_inc[i][DIV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cfg.cfg_error <= 1'b0;
    end else begin
      cfg.cfg_error <= wr_fire & wr_bad;
    end
  end

  always_ff @(posedge clock_in) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        div_q[i]     <= DIV_WIDTH'(DEFAULT_DIVISOR);
        high_q[i]    <= DIV_WIDTH'(DEFAULT_DIVISOR >> 1);
        cnt_q[i]     <= '0;
        pdiv_q[i]    <= '0;
        phigh_q[i]   <= '0;
        pend_q[i]    <= 1'b0;
        sync1_q[i]   <= 1'b0;
        sync2_q[i]   <= 1'b0;
        sync3_q[i]   <= 1'b0;
        clock_out[i] <= 1'b0;
        tick[i]      <= 1'b0;
      end else begin
        sync1_q[i] <= step_divisor[i];
        sync2_q[i] <= sync1_q[i];
        sync3_q[i] <= sync2_q[i];

        if (enable[i]) begin
          clock_out[i] <= (cnt_q[i] < high_q[i]);
          tick[i]      <= (cnt_q[i] == '0);
          if (cnt_q[i] == div_q[i] - DIV_WIDTH'(1)) begin
            cnt_q[i] <= '0;
            if (pend_q[i]) begin
              div_q[i]  <= pdiv_q[i];
              high_q[i] <= phigh_q[i];
              pend_q[i] <= 1'b0;
            end
          end else begin
            cnt_q[i] <= cnt_q[i] + DIV_WIDTH'(1);
          end
        end else begin
          cnt_q[i]     <= '0;
          clock_out[i] <= 1'b0;
          tick[i]      <= 1'b0;
          if (pend_q[i]) begin
            div_q[i]  <= pdiv_q[i];
            high_q[i] <= phigh_q[i];
            pend_q[i] <= 1'b0;
          end
        end

        // A write can only land while pending is clear, so it never races the apply above
        if (wr_fire && !wr_bad && cfg.cfg_channel == CH_W'(i)) begin
          pdiv_q[i]  <= cfg.cfg_divisor;
          phigh_q[i] <= wr_high;
          pend_q[i]  <= 1'b1;
        end else if (step_edge[i] && !pend_q[i]) begin
          pdiv_q[i]  <= step_div[i];
          phigh_q[i] <= step_div[i] >> 1;
          pend_q[i]  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb/tb_multi_channel_clock_divider.sv - directed self-checking bench for multi_channel_clock_divider
module tb_multi_channel_clock_divider;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enable;
  logic [3:0] step_divisor;
  logic [3:0] clock_out, tick, pending;
  int n_checks = 0;
  int n_pass   = 0;

  multi_channel_clock_divider_if #(.CH_W(2), .DIV_WIDTH(16)) cfg_bus ();

  multi_channel_clock_divider #(
    .CHANNELS(4), .DIV_WIDTH(16), .MAX_DIVISION(4), .DEFAULT_DIVISOR(2)
  ) dut (
    .clock_in(clk), .reset(reset), .enable(enable), .cfg(cfg_bus),
    .step_divisor(step_divisor), .clock_out(clock_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic measure(input int ch, input string tag, input int exp_period, input int exp_high);
    int n = 0;
    int period = 0;
    int high_t = 0;
    while (!tick[ch] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tick[ch]) begin
      do begin
        if (clock_out[ch]) high_t++;
        period++;
        @(negedge clk);
      end while (!tick[ch] && period < 200);
    end
    check({tag, "_period"}, period, exp_period);
    check({tag, "_high"}, high_t, exp_high);
  endtask

  task automatic wait_clear(input int ch, input string tag);
    int n = 0;
    while (pending[ch] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, pending[ch]}, 0);
  endtask

  task automatic wait_set(input int ch, input string tag);
    int n = 0;
    while (!pending[ch] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, pending[ch]}, 1);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    cfg_bus.cfg_valid   = 1'b1;
    cfg_bus.cfg_channel = 2'(ch);
    cfg_bus.cfg_divisor = 16'(dv);
    cfg_bus.cfg_high    = 16'(hi);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic step_pulse(input int ch);
    step_divisor[ch] = 1'b1;
    repeat (3) @(negedge clk);
    step_divisor[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    enable = '0;
    step_divisor = '0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_channel = '0;
    cfg_bus.cfg_divisor = '0;
    cfg_bus.cfg_high = '0;
    repeat (3) @(negedge clk);
    check("rst_clock_out", {28'd0, clock_out}, 0);
    check("rst_tick", {28'd0, tick}, 0);
    check("rst_pending", {28'd0, pending}, 0);
    check("rst_cfg_error", {31'd0, cfg_bus.cfg_error}, 0);
    check("rst_cfg_ready", {31'd0, cfg_bus.cfg_ready}, 1);
    reset = 1'b0;
    @(negedge clk);

    // Enable start: first high one cycle after enable is sampled
    enable[0] = 1'b1;
    @(negedge clk);
    check("en_first_high", {31'd0, clock_out[0]}, 1);
    check("en_first_tick", {31'd0, tick[0]}, 1);
    @(negedge clk);
    check("en_second_low", {31'd0, clock_out[0]}, 0);
    measure(0, "ch0_default", 2, 1);

    // Write to running channel 1: held pending until the wrap
    enable[1] = 1'b1;
    repeat (2) @(negedge clk);
    cfg_bus.cfg_channel = 2'd1;
    check("ch1_ready_before", {31'd0, cfg_bus.cfg_ready}, 1);
    cfg_write(1, 5, 2);
    check("ch1_pending", {31'd0, pending[1]}, 1);
    check("ch1_ready_while_pending", {31'd0, cfg_bus.cfg_ready}, 0);
    wait_clear(1, "ch1_applied");
    measure(1, "ch1_new_a", 5, 2);
    measure(1, "ch1_new_b", 5, 2);

    // Rejected divisor and high-time clamping on channel 0
    cfg_write(0, 1, 0);
    check("rej_error", {31'd0, cfg_bus.cfg_error}, 1);
    check("rej_no_pending", {31'd0, pending[0]}, 0);
    @(negedge clk);
    check("rej_error_pulse", {31'd0, cfg_bus.cfg_error}, 0);
    measure(0, "rej_unchanged", 2, 1);
    cfg_write(0, 4, 0);
    wait_clear(0, "clamp0_applied");
    measure(0, "clamp_high0", 4, 2);
    cfg_write(0, 6, 1);
    wait_clear(0, "div6_applied");
    measure(0, "div6_high1", 6, 1);
    cfg_write(0, 4, 9);
    wait_clear(0, "clamp9_applied");
    measure(0, "clamp_high9", 4, 2);

    // Step mode on channel 2 with MAX_DIVISION=4: 2 -> 3 -> 4 -> 2
    enable[2] = 1'b1;
    repeat (2) @(negedge clk);
    step_pulse(2);
    wait_set(2, "step1_pending");
    wait_clear(2, "step1_applied");
    measure(2, "step_div3", 3, 1);
    step_pulse(2);
    wait_set(2, "step2_pending");
    wait_clear(2, "step2_applied");
    measure(2, "step_div4", 4, 2);
    step_pulse(2);
    wait_set(2, "step3_pending");
    wait_clear(2, "step3_applied");
    measure(2, "step_wrap2", 2, 1);

    // Step while a long write is pending is dropped
    cfg_write(2, 40, 20);
    wait_clear(2, "long_applied");
    measure(2, "div40", 40, 20);
    cfg_write(2, 4, 1);
    step_pulse(2);
    repeat (3) @(negedge clk);
    wait_clear(2, "drop_applied");
    measure(2, "drop_step", 4, 1);
    repeat (8) @(negedge clk);
    check("drop_no_repend", {31'd0, pending[2]}, 0);

    // Same-cycle write and step edge on channel 3: the write wins
    enable[3] = 1'b1;
    repeat (2) @(negedge clk);
    step_divisor[3] = 1'b1;
    repeat (2) @(negedge clk);
    cfg_write(3, 7, 3);
    check("same_cycle_pending", {31'd0, pending[3]}, 1);
    step_divisor[3] = 1'b0;
    wait_clear(3, "same_cycle_applied");
    measure(3, "same_cycle_write", 7, 3);
    repeat (8) @(negedge clk);
    check("same_cycle_no_repend", {31'd0, pending[3]}, 0);

    // Reset mid-period with a write pending
    measure(0, "pre_reset", 4, 2);
    cfg_write(0, 9, 4);
    check("pre_reset_pending", {31'd0, pending[0]}, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_clock_out", {28'd0, clock_out}, 0);
    check("mid_rst_pending", {28'd0, pending}, 0);
    check("mid_rst_tick", {28'd0, tick}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_first_high", {31'd0, clock_out[0]}, 1);
    measure(0, "post_rst_ch0", 2, 1);
    measure(3, "post_rst_ch3", 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multi_channel_clock_divider.md
# multi_channel_clock_divider

Parametrised successor of the single-channel adjustable divider. It generates CHANNELS independent divided clocks from one input clock. Each channel has a programmable divisor and high-time. Configuration arrives through a valid/ready write port or a per-channel step input. Every update takes effect only at a period boundary, so no output period is ever truncated. Outputs feed LED blinkers, sample strobes and slow peripheral clock enables.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- DIV_WIDTH, 16: width of divisor and high-time values.
- MAX_DIVISION, 1000: step-mode ceiling. The divisor wraps to 2 when a step would exceed it. Must be ≤ 2^DIV_WIDTH-1.
- DEFAULT_DIVISOR, 2: divisor loaded at reset. Must be ≥ 2.
- CH_W, max(1,$clog2(CHANNELS)): derived width of the channel index.

Ports:
- clock_in  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  CHANNELS  per-channel run enable.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  write accepted when both valid and ready are high.
- cfg_channel  input  CH_W  target channel.
- cfg_divisor  input  DIV_WIDTH  new period, in clock_in cycles.
- cfg_high  input  DIV_WIDTH  new high-time, in clock_in cycles.
- cfg_error  output  1  one-cycle pulse when a write is rejected.
- step_divisor  input  CHANNELS  asynchronous step requests, one per channel.
- clock_out  output  CHANNELS  divided clocks, registered.
- tick  output  CHANNELS  one-cycle pulse at each clock_out rising edge.
- pending  output  CHANNELS  update queued for the channel and not yet applied.

## Operation
- Per-channel state:
  - active divisor D and high-time H,
  - counter C, range 0..D-1,
  - pending divisor PD, pending high-time PH, pending flag.
- Each cycle with enable[i]=1:
  - clock_out[i] <= (C < H)
  - tick[i] <= (C == 0)
  - C <= (C == D-1) ? 0 : C+1
- Wrap: when C == D-1 and pending is set, the next cycle loads D <= PD and H <= PH, and clears pending. The first period after the wrap uses the new values.
- enable[i]=0:
  - C held at 0; clock_out[i] and tick[i] forced to 0.
  - A set pending flag is applied immediately, on the next cycle.
- Write port:
  - cfg_ready = !pending[cfg_channel] (combinational).
  - An accepted write stores PD and PH and sets pending.
  - cfg_divisor < 2 is rejected: accepted but discarded, cfg_error pulses, no state changes.
  - cfg_channel ≥ CHANNELS is rejected the same way.
  - High-time clamp: cfg_high == 0 or cfg_high ≥ cfg_divisor stores PH = cfg_divisor >> 1.
- Step input:
  - Each step_divisor[i] passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge with pending clear sets PD = (D+1 > MAX_DIVISION) ? 2 : D+1, PH = PD >> 1, and sets pending.
  - A step edge while pending is set is dropped.
  - A step edge in the same cycle as an accepted write to the same channel is dropped; the write wins.
- Arithmetic: D+1 is computed at DIV_WIDTH+1 bits, so there is no overflow. All compares are unsigned.

## Timing
- Reset, held for one or more cycles:
  - D = DEFAULT_DIVISOR, H = DEFAULT_DIVISOR >> 1, C = 0.
  - clock_out = 0, tick = 0, pending = 0, cfg_error = 0.
  - Synchronizer and edge-detector flops = 0.
- Reset applies mid-period and mid-handshake: queued updates are discarded.
- Enable start: the cycle after the first cycle with enable[i]=1 sampled, clock_out[i]=1 and tick[i]=1.
- Steady state: period is exactly D cycles, high time exactly H cycles, tick once per period.
- Write to a disabled channel: takes effect 1 cycle after acceptance; pending is high for 1 cycle.
- Write to an enabled channel: takes effect at the next wrap. Latency ≤ D cycles; pending stays high until then.
- Step latency: 3 cycles from the step_divisor edge to pending rising (2 synchronizer cycles + 1 edge-detect cycle), then up to D cycles until applied.
- A write accepted in the same cycle as the wrap applies at the following wrap, not the current one.

## Test plan
- Reset, then enable[0]=1 with defaults: clock_out[0] toggles with period 2 and high 1; tick on every rising edge; first high appears 1 cycle after enable.
- Write ch1 divisor=5, high=2 while running with D=2: pending[1] holds until the wrap; afterwards the period is 5 with high 2; no short period appears; cfg_ready is low for ch1 while pending.
- Rejected writes: divisor=1 gives cfg_error=1 with no change. divisor=4, high=0 gives high=2. divisor=4, high=9 gives high=2.
- With MAX_DIVISION=4, repeated step_divisor[2] pulses: divisor sequence 2→3→4→2. A step while pending is set is ignored.
- Assert reset mid-period with a write pending: next cycle all clock_out=0, pending=0, divisor=DEFAULT_DIVISOR.
- Same-cycle write and step edge on ch3: the write values are applied and the step is dropped.
